// File: rtl/ae_iir_pkg.sv
// Shared types and constants for the cascade SOS IIR coefficient path.
// Coefficients are signed Q2.(SOS_COF_WD-2); the unity value is the passthrough b0.
package ae_iir_pkg;

    localparam int SOS_COF_WD       = 16;
    localparam int SOS_COEF_PER_SEC = 5;
    localparam logic signed [SOS_COF_WD-1:0] SOS_COF_UNITY = SOS_COF_WD'(1 << (SOS_COF_WD - 2));

    typedef struct packed {
        logic signed [SOS_COF_WD-1:0] b0;
        logic signed [SOS_COF_WD-1:0] b1;
        logic signed [SOS_COF_WD-1:0] b2;
        logic signed [SOS_COF_WD-1:0] a1;
        logic signed [SOS_COF_WD-1:0] a2;
    } TYDE_SOS_COEFF_DATA_COF_WD;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_DRAIN  = 2'd2,
        S_COMMIT = 2'd3
    } loader_state_e;

    function automatic TYDE_SOS_COEFF_DATA_COF_WD sos_passthrough();
        TYDE_SOS_COEFF_DATA_COF_WD c;
        c    = '0;
        c.b0 = SOS_COF_UNITY;
        return c;
    endfunction

endpackage

// File: rtl/sos_coeff_bank.sv
// Shadow/active coefficient arrays: words land in the shadow bank, commit_i copies it whole
// to the active bank in one cycle (output registered). No backpressure; both reset to passthrough.
module sos_coeff_bank
    import ae_iir_pkg::*;
#(
    parameter int IIR_SOS_NUM = 4,
    parameter int COF_WD      = SOS_COF_WD,
    parameter int SEC_W       = $clog2(IIR_SOS_NUM + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      wr_en_i,
    input  logic [SEC_W-1:0]          wr_sec_i,
    input  logic [2:0]                wr_fld_i,
    input  logic [COF_WD-1:0]         wr_dat_i,
    input  logic                      commit_i,
    output TYDE_SOS_COEFF_DATA_COF_WD active_o [IIR_SOS_NUM:1]
);

    TYDE_SOS_COEFF_DATA_COF_WD r_shadow [IIR_SOS_NUM:1];
    TYDE_SOS_COEFF_DATA_COF_WD r_active [IIR_SOS_NUM:1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 1; s <= IIR_SOS_NUM; s++) begin
                r_shadow[s] <= sos_passthrough();
                r_active[s] <= sos_passthrough();
            end
        end else begin
            if (wr_en_i) begin
                for (int s = 1; s <= IIR_SOS_NUM; s++) begin
                    if (wr_sec_i == SEC_W'(s)) begin
                        case (wr_fld_i)
                            3'd0:    r_shadow[s].b0 <= wr_dat_i;
                            3'd1:    r_shadow[s].b1 <= wr_dat_i;
                            3'd2:    r_shadow[s].b2 <= wr_dat_i;
                            3'd3:    r_shadow[s].a1 <= wr_dat_i;
                            3'd4:    r_shadow[s].a2 <= wr_dat_i;
                            default: ;
                        endcase
                    end
                end
            end
            // Whole-bank copy so the filter never sees a mix of old and new sections.
            if (commit_i) begin
                r_active <= r_shadow;
            end
        end
    end

    assign active_o = r_active;

endmodule

// File: rtl/sos_coeff_loader.sv
// Frames 5*N coefficient words into a shadow bank and commits atomically; update_o 2 cycles after last word.
// s_ready_o drops only during the single commit cycle or while en_i is low; malformed frames pulse err_o.
module sos_coeff_loader
    import ae_iir_pkg::*;
#(
    parameter int IIR_SOS_NUM = 4,
    parameter int COF_WD      = SOS_COF_WD
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      en_i,
    input  logic                      s_valid_i,
    output logic                      s_ready_o,
    input  logic [COF_WD-1:0]         s_data_i,
    input  logic                      s_last_i,
    output TYDE_SOS_COEFF_DATA_COF_WD coeff_sos_o [IIR_SOS_NUM:1],
    output logic                      update_o,
    output logic                      err_o,
    output logic                      busy_o
);

    localparam int              SEC_W     = $clog2(IIR_SOS_NUM + 1);
    localparam logic [SEC_W-1:0] SEC_FIRST = SEC_W'(1);
    localparam logic [SEC_W-1:0] SEC_LAST  = SEC_W'(IIR_SOS_NUM);
    localparam logic [2:0]       FLD_LAST  = 3'(SOS_COEF_PER_SEC - 1);

    loader_state_e    r_state;
    logic [SEC_W-1:0] r_sec;
    logic [2:0]       r_fld;
    logic             r_update;
    logic             r_err;
    logic             r_busy;

    logic w_accept;
    logic w_final;
    logic w_wr;
    logic w_commit;

    assign s_ready_o = en_i && (r_state != S_COMMIT);
    assign w_accept  = s_valid_i && s_ready_o;
    assign w_final   = (r_sec == SEC_LAST) && (r_fld == FLD_LAST);
    assign w_wr      = w_accept && ((r_state == S_IDLE) || (r_state == S_LOAD));
    assign w_commit  = en_i && (r_state == S_COMMIT);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= S_IDLE;
            r_sec    <= SEC_FIRST;
            r_fld    <= '0;
            r_update <= 1'b0;
            r_err    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_update <= 1'b0;
            r_err    <= 1'b0;
            if (en_i) begin
                case (r_state)
                    S_IDLE: begin
                        // Counters already sit at section 1 / b0 here, so the first word lands there.
                        if (w_accept) begin
                            if (s_last_i) begin
                                r_err <= 1'b1;
                            end else begin
                                r_state <= S_LOAD;
                                r_busy  <= 1'b1;
                                r_fld   <= 3'd1;
                            end
                        end
                    end
                    S_LOAD: begin
                        if (w_accept) begin
                            if (w_final) begin
                                r_sec   <= SEC_FIRST;
                                r_fld   <= '0;
                                r_state <= s_last_i ? S_COMMIT : S_DRAIN;
                            end else if (s_last_i) begin
                                r_sec   <= SEC_FIRST;
                                r_fld   <= '0;
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                                r_err   <= 1'b1;
                            end else if (r_fld == FLD_LAST) begin
                                r_fld <= '0;
                                r_sec <= r_sec + SEC_W'(1);
                            end else begin
                                r_fld <= r_fld + 3'd1;
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (w_accept && s_last_i) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_err   <= 1'b1;
                        end
                    end
                    S_COMMIT: begin
                        r_state  <= S_IDLE;
                        r_busy   <= 1'b0;
                        r_update <= 1'b1;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    sos_coeff_bank #(
        .IIR_SOS_NUM (IIR_SOS_NUM),
        .COF_WD      (COF_WD),
        .SEC_W       (SEC_W)
    ) u_bank (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .wr_en_i  (w_wr),
        .wr_sec_i (r_sec),
        .wr_fld_i (r_fld),
        .wr_dat_i (s_data_i),
        .commit_i (w_commit),
        .active_o (coeff_sos_o)
    );

    assign update_o = r_update;
    assign err_o    = r_err;
    assign busy_o   = r_busy;

endmodule

// File: tb/tb_sos_coeff_loader.sv
// Bench for sos_coeff_loader with N=2, COF_WD=16: frame-level reference model of commits and rejects.
module tb_sos_coeff_loader;
    import ae_iir_pkg::*;

    localparam int N  = 2;
    localparam int FL = 5 * N;

    typedef struct {
        logic [15:0] d;
        logic        l;
        int          c;
    } acc_t;

    logic clk = 1'b0;
    logic rst_n, en, s_valid, s_last;
    logic [15:0] s_data;
    logic s_ready_o, update_o, err_o, busy_o;
    TYDE_SOS_COEFF_DATA_COF_WD coeff [N:1];

    sos_coeff_loader #(.IIR_SOS_NUM(N), .COF_WD(16)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .en_i        (en),
        .s_valid_i   (s_valid),
        .s_ready_o   (s_ready_o),
        .s_data_i    (s_data),
        .s_last_i    (s_last),
        .coeff_sos_o (coeff),
        .update_o    (update_o),
        .err_o       (err_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int bad_ready = 0;
    acc_t sent_q[$];
    logic [15:0] frame_w[$];
    int obs_upd_q[$], obs_err_q[$], exp_upd_q[$], exp_err_q[$];
    TYDE_SOS_COEFF_DATA_COF_WD model_active [N:1];
    TYDE_SOS_COEFF_DATA_COF_WD pass;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (update_o === 1'b1) obs_upd_q.push_back(cyc);
        if (err_o === 1'b1) obs_err_q.push_back(cyc);
        if (en === 1'b0 && s_ready_o !== 1'b0) bad_ready++;
    end

    // Reference: a frame is everything up to an accepted last word; only exactly 5N words commit.
    task automatic model_update();
        acc_t a;
        while (sent_q.size() > 0) begin
            a = sent_q.pop_front();
            frame_w.push_back(a.d);
            if (a.l) begin
                if (frame_w.size() == FL) begin
                    for (int s = 1; s <= N; s++) begin
                        model_active[s].b0 = frame_w[(s-1)*5 + 0];
                        model_active[s].b1 = frame_w[(s-1)*5 + 1];
                        model_active[s].b2 = frame_w[(s-1)*5 + 2];
                        model_active[s].a1 = frame_w[(s-1)*5 + 3];
                        model_active[s].a2 = frame_w[(s-1)*5 + 4];
                    end
                    exp_upd_q.push_back(a.c + 2);
                end else begin
                    exp_err_q.push_back(a.c + 1);
                end
                frame_w.delete();
            end
        end
    endtask

    task automatic clear_obs();
        obs_upd_q.delete(); obs_err_q.delete(); exp_upd_q.delete(); exp_err_q.delete();
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [15:0] base, input int n, input int last_at,
                              input bit gaps, input bit rnd, input bit hold,
                              output int first_c, output int last_c);
        logic [15:0] d;
        int g, waitc;
        bit got;
        first_c = -1;
        last_c  = -1;
        for (int i = 0; i < n; i++) begin
            d = rnd ? 16'($urandom) : base + 16'(i);
            g = gaps ? int'($urandom_range(0, 2)) : 0;
            if (g > 0) begin
                s_valid = 1'b0;
                repeat (g) begin @(posedge clk); #1; end
            end
            s_valid = 1'b1; s_data = d; s_last = (i + 1 == last_at);
            got = 1'b0; waitc = 0;
            while (!got && waitc < 64) begin
                @(negedge clk); #1;
                if (s_ready_o === 1'b1 && en === 1'b1) got = 1'b1;
                else waitc++;
            end
            if (got) begin
                sent_q.push_back('{d: d, l: s_last, c: cyc});
                if (i == 0) first_c = cyc;
                last_c = cyc;
            end else begin
                n_checks++; n_fail++;
                $display("FAIL handshake_timeout: word %0d not accepted within 64 cycles, acceptance required", i);
            end
            @(posedge clk); #1;
        end
        if (!hold) begin s_valid = 1'b0; s_last = 1'b0; end
    endtask

    task automatic test_reset();
        n_checks++; if (s_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", s_ready_o); end
        n_checks++; if (update_o !== 1'b0) begin n_fail++; $display("FAIL reset_update: got %b required 0", update_o); end
        n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b required 0", err_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy_o); end
        for (int s = 1; s <= N; s++) begin
            n_checks++; if (coeff[s] !== pass) begin n_fail++; $display("FAIL reset_coeff sec%0d: got %h required %h", s, coeff[s], pass); end
        end
    endtask

    task automatic test_good_frame();
        int f, l;
        clear_obs();
        send_frame(16'h0001, 10, 10, 1'b0, 1'b0, 1'b0, f, l);
        n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL good_busy_commit: got %b required 1", busy_o); end
        n_checks++; if (s_ready_o !== 1'b0) begin n_fail++; $display("FAIL good_ready_commit: got %b required 0", s_ready_o); end
        settle(); model_update();
        n_checks++; if (obs_upd_q.size() != exp_upd_q.size()) begin n_fail++; $display("FAIL good_upd_count: got %0d required %0d", obs_upd_q.size(), exp_upd_q.size()); end
        else foreach (exp_upd_q[i]) begin n_checks++; if (obs_upd_q[i] != exp_upd_q[i]) begin n_fail++; $display("FAIL good_upd_cycle: got %0d required %0d", obs_upd_q[i], exp_upd_q[i]); end end
        n_checks++; if (obs_err_q.size() != exp_err_q.size()) begin n_fail++; $display("FAIL good_err_count: got %0d required %0d", obs_err_q.size(), exp_err_q.size()); end
        for (int s = 1; s <= N; s++) begin
            n_checks++; if (coeff[s] !== model_active[s]) begin n_fail++; $display("FAIL good_coeff sec%0d: got %h required %h", s, coeff[s], model_active[s]); end
        end
        n_checks++; if (coeff[2].a2 !== 16'sh000A) begin n_fail++; $display("FAIL good_sec2_a2: got %h required 000a", coeff[2].a2); end
    endtask

    task automatic test_early_last();
        int f, l;
        clear_obs();
        send_frame(16'h0050, 4, 4, 1'b0, 1'b0, 1'b0, f, l);
        settle();
        for (int s = 1; s <= N; s++) begin
            n_checks++; if (coeff[s] !== model_active[s]) begin n_fail++; $display("FAIL early_unchanged sec%0d: got %h required %h", s, coeff[s], model_active[s]); end
        end
        send_frame(16'h0100, 10, 10, 1'b0, 1'b0, 1'b0, f, l);
        settle(); model_update();
        n_checks++; if (obs_err_q.size() != exp_err_q.size()) begin n_fail++; $display("FAIL early_err_count: got %0d required %0d", obs_err_q.size(), exp_err_q.size()); end
        else foreach (exp_err_q[i]) begin n_checks++; if (obs_err_q[i] != exp_err_q[i]) begin n_fail++; $display("FAIL early_err_cycle: got %0d required %0d", obs_err_q[i], exp_err_q[i]); end end
        n_checks++; if (obs_upd_q.size() != exp_upd_q.size()) begin n_fail++; $display("FAIL early_upd_count: got %0d required %0d", obs_upd_q.size(), exp_upd_q.size()); end
        else foreach (exp_upd_q[i]) begin n_checks++; if (obs_upd_q[i] != exp_upd_q[i]) begin n_fail++; $display("FAIL early_upd_cycle: got %0d required %0d", obs_upd_q[i], exp_upd_q[i]); end end
        for (int s = 1; s <= N; s++) begin
            n_checks++; if (coeff[s] !== model_active[s]) begin n_fail++; $display("FAIL early_next_coeff sec%0d: got %h required %h", s, coeff[s], model_active[s]); end
        end
    endtask

    task automatic test_overlong();
        int f, l;
        clear_obs();
        send_frame(16'h0A00, 12, 12, 1'b0, 1'b0, 1'b0, f, l);
        settle(); model_update();
        n_checks++; if (obs_err_q.size() != exp_err_q.size()) begin n_fail++; $display("FAIL long_err_count: got %0d required %0d", obs_err_q.size(), exp_err_q.size()); end
        else foreach (exp_err_q[i]) begin n_checks++; if (obs_err_q[i] != exp_err_q[i]) begin n_fail++; $display("FAIL long_err_cycle: got %0d required %0d", obs_err_q[i], exp_err_q[i]); end end
        n_checks++; if (obs_upd_q.size() != exp_upd_q.size()) begin n_fail++; $display("FAIL long_upd_count: got %0d required %0d", obs_upd_q.size(), exp_upd_q.size()); end
        for (int s = 1; s <= N; s++) begin
            n_checks++; if (coeff[s] !== model_active[s]) begin n_fail++; $display("FAIL long_coeff sec%0d: got %h required %h", s, coeff[s], model_active[s]); end
        end
    endtask

    task automatic test_random_enable();
        int f1, l1, f2, l2, en_lo_at, in_win;
        clear_obs();
        bad_ready = 0;
        en_lo_at = 0;
        fork
            send_frame(16'h0, 10, 10, 1'b1, 1'b1, 1'b0, f1, l1);
            begin
                repeat (4) @(posedge clk);
                #1; en = 1'b0; en_lo_at = cyc;
                repeat (3) @(posedge clk);
                #1; en = 1'b1;
            end
        join
        in_win = 0;
        foreach (sent_q[i]) if (sent_q[i].c > en_lo_at && sent_q[i].c <= en_lo_at + 3) in_win++;
        n_checks++; if (in_win != 0) begin n_fail++; $display("FAIL en_low_accepts: got %0d words required 0", in_win); end
        send_frame(16'h0, 10, 10, 1'b1, 1'b1, 1'b0, f2, l2);
        settle(); model_update();
        n_checks++; if (bad_ready != 0) begin n_fail++; $display("FAIL en_low_ready: got %0d cycles with ready required 0", bad_ready); end
        n_checks++; if (obs_upd_q.size() != exp_upd_q.size()) begin n_fail++; $display("FAIL rnd_upd_count: got %0d required %0d", obs_upd_q.size(), exp_upd_q.size()); end
        else foreach (exp_upd_q[i]) begin n_checks++; if (obs_upd_q[i] != exp_upd_q[i]) begin n_fail++; $display("FAIL rnd_upd_cycle: got %0d required %0d", obs_upd_q[i], exp_upd_q[i]); end end
        n_checks++; if (obs_err_q.size() != exp_err_q.size()) begin n_fail++; $display("FAIL rnd_err_count: got %0d required %0d", obs_err_q.size(), exp_err_q.size()); end
        for (int s = 1; s <= N; s++) begin
            n_checks++; if (coeff[s] !== model_active[s]) begin n_fail++; $display("FAIL rnd_coeff sec%0d: got %h required %h", s, coeff[s], model_active[s]); end
        end
    endtask

    task automatic test_back_to_back();
        int f1, l1, f2, l2;
        clear_obs();
        send_frame(16'h0, 10, 10, 1'b0, 1'b1, 1'b1, f1, l1);
        send_frame(16'h0, 10, 10, 1'b0, 1'b1, 1'b0, f2, l2);
        n_checks++; if (f2 != l1 + 2) begin n_fail++; $display("FAIL b2b_bubble: second frame first word at cycle %0d required %0d", f2, l1 + 2); end
        n_checks++; if (l2 != f2 + FL - 1) begin n_fail++; $display("FAIL b2b_stream: second frame last word at cycle %0d required %0d", l2, f2 + FL - 1); end
        settle(); model_update();
        n_checks++; if (obs_upd_q.size() != exp_upd_q.size()) begin n_fail++; $display("FAIL b2b_upd_count: got %0d required %0d", obs_upd_q.size(), exp_upd_q.size()); end
        else foreach (exp_upd_q[i]) begin n_checks++; if (obs_upd_q[i] != exp_upd_q[i]) begin n_fail++; $display("FAIL b2b_upd_cycle: got %0d required %0d", obs_upd_q[i], exp_upd_q[i]); end end
        for (int s = 1; s <= N; s++) begin
            n_checks++; if (coeff[s] !== model_active[s]) begin n_fail++; $display("FAIL b2b_coeff sec%0d: got %h required %h", s, coeff[s], model_active[s]); end
        end
    endtask

    task automatic test_reset_mid();
        int f, l;
        clear_obs();
        send_frame(16'h0300, 6, 0, 1'b0, 1'b0, 1'b0, f, l);
        model_update();
        rst_n = 1'b0;
        #1;
        frame_w.delete();
        for (int s = 1; s <= N; s++) model_active[s] = pass;
        for (int s = 1; s <= N; s++) begin
            n_checks++; if (coeff[s] !== pass) begin n_fail++; $display("FAIL rstmid_coeff sec%0d: got %h required %h", s, coeff[s], pass); end
        end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b required 0", busy_o); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        clear_obs();
        send_frame(16'h0400, 10, 10, 1'b0, 1'b0, 1'b0, f, l);
        settle(); model_update();
        n_checks++; if (obs_upd_q.size() != exp_upd_q.size()) begin n_fail++; $display("FAIL rstmid_upd_count: got %0d required %0d", obs_upd_q.size(), exp_upd_q.size()); end
        for (int s = 1; s <= N; s++) begin
            n_checks++; if (coeff[s] !== model_active[s]) begin n_fail++; $display("FAIL rstmid_next_coeff sec%0d: got %h required %h", s, coeff[s], model_active[s]); end
        end
        n_checks++; if (coeff[1].b0 !== 16'sh0400) begin n_fail++; $display("FAIL rstmid_first_word: got %h required 0400", coeff[1].b0); end
    endtask

    initial begin
        pass    = '0;
        pass.b0 = 16'sh4000;
        for (int s = 1; s <= N; s++) model_active[s] = pass;
        rst_n = 1'b0; en = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_good_frame();
        test_early_last();
        test_overlong();
        test_random_enable();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
